// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use stall, branch flush, fetch stall, data-memory freeze/timeout
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   ifidRs1/ifidRs2              ID-stage source registers, qualified by ifidUsesRs1/ifidUsesRs2
//   idexRd, idexMemRead          EX-stage destination register and load flag
//   exBranchTaken                branch/jump resolved taken in EX
//   exmemMemReq, dmemReady       MEM-stage access pending / data memory completes this cycle
//   imemReady                    instruction fetch completes this cycle
//   pcWrite..exmemWrite          pipeline register enables
//   ifidFlush..memwbFlush        bubble insertion per pipeline register
//   memErr                       sticky data-memory timeout flag
//   stallCount                   saturating count of PC-stall cycles
//   ctrlState                    FSM state (RUN=0, MEM_WAIT=1, ERROR=2)
module hazard_ctrl #(
    parameter int RF_ADDR_WIDTH = 5,
    parameter int MEM_TIMEOUT   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [RF_ADDR_WIDTH-1:0] ifidRs1,
    input  logic [RF_ADDR_WIDTH-1:0] ifidRs2,
    input  logic                     ifidUsesRs1,
    input  logic                     ifidUsesRs2,
    input  logic [RF_ADDR_WIDTH-1:0] idexRd,
    input  logic                     idexMemRead,
    input  logic                     exBranchTaken,
    input  logic                     exmemMemReq,
    input  logic                     dmemReady,
    input  logic                     imemReady,
    output logic                     pcWrite,
    output logic                     ifidWrite,
    output logic                     idexWrite,
    output logic                     exmemWrite,
    output logic                     ifidFlush,
    output logic                     idexFlush,
    output logic                     memwbFlush,
    output logic                     memErr,
    output logic [31:0]              stallCount,
    output logic [1:0]               ctrlState
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;

    // waitCnt holds the number of freeze cycles already seen, so the freeze
    // cycle that finds it at MEM_TIMEOUT-1 is the MEM_TIMEOUT-th one.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] stall_count_q, stall_count_d;

    logic freeze;
    logic load_use;

    always_comb begin
        freeze   = exmemMemReq && !dmemReady;
        load_use = idexMemRead && (idexRd != '0) &&
                   ((ifidUsesRs1 && (idexRd == ifidRs1)) ||
                    (ifidUsesRs2 && (idexRd == ifidRs2)));
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        pcWrite    = 1'b1;
        ifidWrite  = 1'b1;
        idexWrite  = 1'b1;
        exmemWrite = 1'b1;
        ifidFlush  = 1'b0;
        idexFlush  = 1'b0;
        memwbFlush = 1'b0;
        memErr     = 1'b0;

        case (state_q)
            ST_ERROR: begin
                // Pipeline is frozen with MEM/WB bubbled until reset.
                pcWrite    = 1'b0;
                ifidWrite  = 1'b0;
                idexWrite  = 1'b0;
                exmemWrite = 1'b0;
                memwbFlush = 1'b1;
                memErr     = 1'b1;
            end
            default: begin
                if (freeze) begin
                    // Freeze wins over everything, including a held branch.
                    pcWrite    = 1'b0;
                    ifidWrite  = 1'b0;
                    idexWrite  = 1'b0;
                    exmemWrite = 1'b0;
                    memwbFlush = 1'b1;
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    state_d    = (wait_cnt_q == TIMEOUT_LAST) ? ST_ERROR : ST_MEM_WAIT;
                end else begin
                    wait_cnt_d = 8'd0;
                    state_d    = ST_RUN;
                    if (exBranchTaken) begin
                        ifidFlush = 1'b1;
                        idexFlush = 1'b1;
                    end else if (load_use) begin
                        // Hold PC and IF/ID one cycle; bubble into ID/EX.
                        pcWrite   = 1'b0;
                        ifidWrite = 1'b0;
                        idexFlush = 1'b1;
                    end else if (!imemReady) begin
                        pcWrite   = 1'b0;
                        ifidFlush = 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (!pcWrite && (state_q != ST_ERROR) && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= 8'd0;
            stall_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stallCount = stall_count_q;
    assign ctrlState  = state_q;

endmodule
